// File: rtl/irq_priority_ctrl.sv
// -----------------------------------------------------------------------------
// irq_priority_ctrl
//   Three-line priority interrupt controller. Raw lines are synchronized,
//   rising-edge detected and latched as pending requests. A CPU-written mask
//   disables lines without dropping their pending bits. One request at a time
//   is presented to the CPU together with its handler vector; in-service
//   tracking blocks equal/lower lines until the handler returns (eret).
//   Higher index = higher priority.
//
//   Optional feature macro: IRQ_NESTING_EN
//     defined   : a line above the highest in-service line may be requested
//                 (nesting up to 3 deep).
//     undefined : nothing is requested while any line is in service.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   irq_in      raw asynchronous interrupt lines (bit i = int i)
//   mask_we     mask register write strobe
//   mask_wdata  new mask value (1 = line disabled)
//   int_ack     CPU entered the handler for int_id (one-cycle pulse)
//   eret        CPU returned from the current handler (one-cycle pulse)
//   int_req     interrupt request to the CPU
//   int_id      index of the requested line
//   int_vector  VEC_BASE + int_id * VEC_STRIDE
//   pending     latched pending bits
//   in_service  in-service bits
//   mask        current mask register
// -----------------------------------------------------------------------------
module irq_priority_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_3000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic        mask_we,
    input  logic [2:0]  mask_wdata,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic [1:0]  int_id,
    output logic [31:0] int_vector,
    output logic [2:0]  pending,
    output logic [2:0]  in_service,
    output logic [2:0]  mask
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // One-hot decode of a line index; out-of-range index selects nothing.
    function automatic logic [2:0] line_onehot(input logic [1:0] id);
        logic [2:0] oh;
        case (id)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Clears the highest set in-service bit (the handler being returned from).
    function automatic logic [2:0] clear_highest(input logic [2:0] v);
        logic [2:0] r;
        if (v[2]) begin
            r = {1'b0, v[1:0]};
        end else if (v[1]) begin
            r = {v[2], 1'b0, v[0]};
        end else begin
            r = {v[2:1], 1'b0};
        end
        return r;
    endfunction

    // Lines allowed to preempt, given the current in-service set.
    function automatic logic [2:0] allowed_lines(input logic [2:0] isv);
        logic [2:0] a;
`ifdef IRQ_NESTING_EN
        if (isv[2]) begin
            a = 3'b000;
        end else if (isv[1]) begin
            a = 3'b100;
        end else if (isv[0]) begin
            a = 3'b110;
        end else begin
            a = 3'b111;
        end
`else
        if (isv != 3'b000) begin
            a = 3'b000;
        end else begin
            a = 3'b111;
        end
`endif
        return a;
    endfunction

    logic [2:0]  sync1_q, sync2_q, prev_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  in_service_q, in_service_d;
    logic [2:0]  mask_q, mask_d;
    logic [0:0]  state_q, state_d;
    logic        int_req_q, int_req_d;
    logic [1:0]  int_id_q, int_id_d;
    logic [31:0] int_vector_q, int_vector_d;

    logic [2:0]  edge_s;
    logic [2:0]  eligible_s;
    logic [1:0]  winner_s;
    logic [2:0]  pend_s;
    logic [2:0]  isv_s;

    assign edge_s     = sync2_q & ~prev_q;
    assign eligible_s = pending_q & ~mask_q & allowed_lines(in_service_q);

    // Highest eligible index wins.
    always_comb begin
        if (eligible_s[2]) begin
            winner_s = 2'd2;
        end else if (eligible_s[1]) begin
            winner_s = 2'd1;
        end else begin
            winner_s = 2'd0;
        end
    end

    // Next-state logic: request FSM, pending/in-service bookkeeping, mask.
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_id_d     = int_id_q;
        int_vector_d = int_vector_q;
        pend_s       = pending_q;
        // eret is applied before an ack in the same cycle.
        if (eret && (in_service_q != 3'b000)) begin
            isv_s = clear_highest(in_service_q);
        end else begin
            isv_s = in_service_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (eligible_s != 3'b000) begin
                    int_req_d    = 1'b1;
                    int_id_d     = winner_s;
                    int_vector_d = VEC_BASE + (VEC_STRIDE * {30'd0, winner_s});
                    state_d      = ST_REQ;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_REQ: begin
                // id/vector are frozen here; only an ack releases the request.
                if (int_ack) begin
                    pend_s    = pend_s & ~line_onehot(int_id_q);
                    isv_s     = isv_s | line_onehot(int_id_q);
                    int_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_REQ;
                end
            end
            default: begin
                int_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        // A new edge wins over an ack clear of the same line.
        pending_d    = pend_s | edge_s;
        in_service_d = isv_s;
        if (mask_we) begin
            mask_d = mask_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            prev_q       <= 3'b000;
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            mask_q       <= 3'b000;
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            int_id_q     <= 2'd0;
            int_vector_q <= VEC_BASE;
        end else begin
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            int_vector_q <= int_vector_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule
